// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter slice.
package dmem_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam int PORT_CPU     = 0;
   localparam int PORT_DMA     = 1;
   localparam int DEPTH_DEF    = 257;
   localparam int LOCK_MAX_DEF = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request, write payload and response.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   logic              req;
   logic              wr;
   logic              lock;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;
   logic              err;

   modport master (
      output req, wr, lock, addr, wdata,
      input  ack, rvalid, rdata, err
   );

   modport slave (
      input  req, wr, lock, addr, wdata,
      output ack, rvalid, rdata, err
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; mask removes ports that may not be granted this cycle.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   input  logic [1:0] mask,
   output logic [1:0] gnt
);

   logic [1:0] eligible;

   assign eligible = req & mask;

   always_comb begin
      gnt = eligible;
      // On a tie the port that did not win last time goes first.
      if (eligible == 2'b11) begin
         gnt = last_grant ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one single-port data memory between the CPU (port 0) and DMA/debug (port 1).
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = DEPTH_DEF,
   parameter int LOCK_MAX = LOCK_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   dmem_arbiter_if.slave     p0,
   dmem_arbiter_if.slave     p1,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_read_data
);

   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_q, last_d;

   logic [1:0]        req, mask, gnt_raw, gnt;
   logic              any, sel, sel_wr, sel_lock, in_range;
   logic              owner_req, owner_lock;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [1:0]        rvld_p1, err_p1;

   assign req  = {p1.req, p0.req};
   assign mask = (state_q == ARB) ? 2'b11 : (owner_q ? 2'b10 : 2'b01);

   rr_arb2 u_rr (
      .req        (req),
      .last_grant (last_q),
      .mask       (mask),
      .gnt        (gnt_raw)
   );

   assign gnt       = rst_n ? gnt_raw : 2'b00;
   assign any       = |gnt;
   assign sel       = gnt[1];
   assign sel_addr  = sel ? p1.addr  : p0.addr;
   assign sel_wdata = sel ? p1.wdata : p0.wdata;
   assign sel_wr    = sel ? p1.wr    : p0.wr;
   assign sel_lock  = sel ? p1.lock  : p0.lock;
   assign in_range  = sel_addr < ADDR_W'(DEPTH);

   assign owner_req  = owner_q ? p1.req  : p0.req;
   assign owner_lock = owner_q ? p1.lock : p0.lock;

   assign p0.ack = gnt[0];
   assign p1.ack = gnt[1];

   // Out-of-range accesses are acked but never reach the memory.
   assign mem_address    = any ? sel_addr  : '0;
   assign mem_write_data = any ? sel_wdata : '0;
   assign mem_rd         = any && !sel_wr && in_range;
   assign mem_wr         = any &&  sel_wr && in_range;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      last_d  = any ? sel : last_q;
      case (state_q)
         ARB: begin
            if (any && sel_lock && LOCK_MAX > 1) begin
               state_d = LOCKED;
               owner_d = sel;
               cnt_d   = CNT_W'(1);
            end
         end
         LOCKED: begin
            // This access is number cnt_q+1; the LOCK_MAXth one forces release.
            if (any) begin
               if (!sel_lock || cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                  state_d = ARB;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (!owner_req && !owner_lock) begin
               state_d = ARB;
               cnt_d   = '0;
            end
         end
         default: state_d = ARB;
      endcase
   end

   // Stage p0 -> p1: response flags follow the memory's one-cycle read latency.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ARB;
         owner_q <= 1'(PORT_CPU);
         cnt_q   <= '0;
         last_q  <= 1'(PORT_DMA);
         rvld_p1 <= 2'b00;
         err_p1  <= 2'b00;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         rvld_p1 <= gnt & {2{!sel_wr && in_range}};
         err_p1  <= gnt & {2{!in_range}};
      end
   end

   assign p0.rvalid = rvld_p1[0];
   assign p1.rvalid = rvld_p1[1];
   assign p0.rdata  = rvld_p1[0] ? mem_read_data : '0;
   assign p1.rdata  = rvld_p1[1] ? mem_read_data : '0;
   assign p0.err    = err_p1[0];
   assign p1.err    = err_p1[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read memory model.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load_en;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_write_data;
   logic [DW-1:0] mem_read_data = '0;
   logic          mem_rd, mem_wr;
   logic [DW-1:0] mem [0:511] = '{default: '0};

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0 ();
   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1 ();

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(257), .LOCK_MAX(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .p0             (p0),
      .p1             (p1),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_rd         (mem_rd),
      .mem_wr         (mem_wr),
      .mem_read_data  (mem_read_data)
   );

   always @(posedge clk) begin
      if (load_en) mem[5] <= 32'hDEADBEEF;
      if (mem_wr) mem[mem_address[8:0]] <= mem_write_data;
      if (mem_rd) mem_read_data <= mem[mem_address[8:0]];
   end

   task automatic idle_inputs();
      p0.req = 0; p0.wr = 0; p0.lock = 0; p0.addr = '0; p0.wdata = '0;
      p1.req = 0; p1.wr = 0; p1.lock = 0; p1.addr = '0; p1.wdata = '0;
   endtask

   task automatic test_reset();
      rst_n = 0; load_en = 1; idle_inputs();
      p0.req = 1; p0.addr = 5;
      @(negedge clk); @(negedge clk); #1;
      tests_run++; if (p0.ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack0 got %b want 0", p0.ack); end
      tests_run++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin tests_failed++; $display("FAIL reset_strobes got rd=%b wr=%b want 0 0", mem_rd, mem_wr); end
      tests_run++; if (p0.rvalid !== 1'b0 || p0.err !== 1'b0 || p0.rdata !== '0) begin tests_failed++; $display("FAIL reset_resp got rvalid=%b err=%b rdata=%h want 0 0 0", p0.rvalid, p0.err, p0.rdata); end
      p0.req = 0; load_en = 0;
      @(negedge clk); rst_n = 1;
   endtask

   task automatic test_read();
      @(negedge clk); p0.req = 1; p0.wr = 0; p0.addr = 5; #1;
      tests_run++; if (p0.ack !== 1'b1 || p1.ack !== 1'b0) begin tests_failed++; $display("FAIL read_ack got ack0=%b ack1=%b want 1 0", p0.ack, p1.ack); end
      tests_run++; if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_address !== 32'd5) begin tests_failed++; $display("FAIL read_bus got rd=%b wr=%b addr=%0d want 1 0 5", mem_rd, mem_wr, mem_address); end
      @(negedge clk); p0.req = 0; #1;
      tests_run++; if (p0.rvalid !== 1'b1 || p0.rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL read_data got rvalid0=%b rdata0=%h want 1 deadbeef", p0.rvalid, p0.rdata); end
      tests_run++; if (p1.rvalid !== 1'b0 || mem_wr !== 1'b0) begin tests_failed++; $display("FAIL read_side got rvalid1=%b wr=%b want 0 0", p1.rvalid, mem_wr); end
   endtask

   task automatic test_out_of_range();
      @(negedge clk); p1.req = 1; p1.wr = 0; p1.addr = 300; #1;
      tests_run++; if (p1.ack !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin tests_failed++; $display("FAIL oor_ack got ack1=%b rd=%b wr=%b want 1 0 0", p1.ack, mem_rd, mem_wr); end
      @(negedge clk); p1.req = 0; #1;
      tests_run++; if (p1.err !== 1'b1 || p1.rvalid !== 1'b0 || p1.rdata !== '0) begin tests_failed++; $display("FAIL oor_err got err1=%b rvalid1=%b rdata1=%h want 1 0 0", p1.err, p1.rvalid, p1.rdata); end
      tests_run++; if (p0.err !== 1'b0) begin tests_failed++; $display("FAIL oor_err0 got %b want 0", p0.err); end
      @(negedge clk); #1;
      tests_run++; if (p1.err !== 1'b0) begin tests_failed++; $display("FAIL oor_pulse got err1=%b want 0", p1.err); end
   endtask

   task automatic test_rr_writes();
      int exp_port [4] = '{0, 1, 0, 1};
      int exp_addr [4] = '{20, 30, 21, 31};
      int n0 = 0, n1 = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         p0.req = 1; p0.wr = 1; p0.addr = 20 + n0; p0.wdata = 32'hA000_0000 | (20 + n0);
         p1.req = 1; p1.wr = 1; p1.addr = 30 + n1; p1.wdata = 32'hA000_0000 | (30 + n1);
         #1;
         tests_run++; if (p0.ack !== (exp_port[k] == 0) || p1.ack !== (exp_port[k] == 1)) begin tests_failed++; $display("FAIL rr_ack[%0d] got ack0=%b ack1=%b want port %0d", k, p0.ack, p1.ack, exp_port[k]); end
         tests_run++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_address !== exp_addr[k] || mem_write_data !== (32'hA000_0000 | exp_addr[k])) begin tests_failed++; $display("FAIL rr_bus[%0d] got wr=%b rd=%b addr=%0d data=%h want 1 0 %0d", k, mem_wr, mem_rd, mem_address, mem_write_data, exp_addr[k]); end
         if (exp_port[k] == 1) n1++; else n0++;
      end
      @(negedge clk); idle_inputs(); #1;
      tests_run++; if (mem[20] !== 32'hA000_0014 || mem[21] !== 32'hA000_0015) begin tests_failed++; $display("FAIL rr_mem0 got %h %h want a0000014 a0000015", mem[20], mem[21]); end
      tests_run++; if (mem[30] !== 32'hA000_001E || mem[31] !== 32'hA000_001F) begin tests_failed++; $display("FAIL rr_mem1 got %h %h want a000001e a000001f", mem[30], mem[31]); end
   endtask

   task automatic test_write_read();
      @(negedge clk); p1.req = 1; p1.wr = 1; p1.addr = 10; p1.wdata = 32'h12345678; #1;
      tests_run++; if (p1.ack !== 1'b1 || mem_wr !== 1'b1 || mem_address !== 32'd10) begin tests_failed++; $display("FAIL wr_ack got ack1=%b wr=%b addr=%0d want 1 1 10", p1.ack, mem_wr, mem_address); end
      @(negedge clk); idle_inputs(); p0.req = 1; p0.wr = 0; p0.addr = 10; #1;
      tests_run++; if (p0.ack !== 1'b1 || mem_rd !== 1'b1) begin tests_failed++; $display("FAIL rd_ack got ack0=%b rd=%b want 1 1", p0.ack, mem_rd); end
      @(negedge clk); p0.req = 0; #1;
      tests_run++; if (p0.rvalid !== 1'b1 || p0.rdata !== 32'h12345678) begin tests_failed++; $display("FAIL wr_rd_data got rvalid0=%b rdata0=%h want 1 12345678", p0.rvalid, p0.rdata); end
   endtask

   task automatic test_lock();
      int n1 = 0;
      p0.wr = 1; p0.addr = 50; p0.wdata = 32'h50;
      p1.wr = 1; p1.lock = 1;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         p0.req = (c <= 4); p1.req = 1; p1.addr = 40 + n1; p1.wdata = 32'h40 + n1;
         #1;
         tests_run++; if (p0.ack !== (c == 4) || p1.ack !== (c != 4)) begin tests_failed++; $display("FAIL lock_ack[%0d] got ack0=%b ack1=%b want %b %b", c, p0.ack, p1.ack, c == 4, c != 4); end
         if (c != 4) n1++;
      end
      // Owner idles with lock held: the other port must still wait.
      @(negedge clk); p1.req = 0; p1.lock = 1; p0.req = 1; p0.addr = 51; #1;
      tests_run++; if (p0.ack !== 1'b0 || mem_wr !== 1'b0 || mem_rd !== 1'b0 || mem_address !== '0) begin tests_failed++; $display("FAIL lock_hold got ack0=%b wr=%b rd=%b addr=%0d want 0 0 0 0", p0.ack, mem_wr, mem_rd, mem_address); end
      @(negedge clk); p1.lock = 0; #1;
      tests_run++; if (p0.ack !== 1'b0) begin tests_failed++; $display("FAIL lock_release_cycle got ack0=%b want 0", p0.ack); end
      @(negedge clk); #1;
      tests_run++; if (p0.ack !== 1'b1 || mem_address !== 32'd51) begin tests_failed++; $display("FAIL lock_after got ack0=%b addr=%0d want 1 51", p0.ack, mem_address); end
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_reset_mid_read();
      @(negedge clk); p0.req = 1; p0.wr = 0; p0.addr = 10; #1;
      tests_run++; if (p0.ack !== 1'b1) begin tests_failed++; $display("FAIL mid_ack got ack0=%b want 1", p0.ack); end
      #1; rst_n = 0; p0.req = 0; p1.req = 1; p1.wr = 0; p1.addr = 5; #1;
      tests_run++; if (p1.ack !== 1'b0 || mem_rd !== 1'b0) begin tests_failed++; $display("FAIL mid_gate got ack1=%b rd=%b want 0 0", p1.ack, mem_rd); end
      @(negedge clk); #1;
      tests_run++; if (p0.rvalid !== 1'b0 || p0.rdata !== '0 || p1.rvalid !== 1'b0) begin tests_failed++; $display("FAIL mid_resp got rvalid0=%b rdata0=%h rvalid1=%b want 0 0 0", p0.rvalid, p0.rdata, p1.rvalid); end
      @(negedge clk); rst_n = 1; p0.req = 1; p0.addr = 5; p1.req = 1; p1.addr = 10; #1;
      tests_run++; if (p0.ack !== 1'b1 || p1.ack !== 1'b0) begin tests_failed++; $display("FAIL post_tie got ack0=%b ack1=%b want 1 0", p0.ack, p1.ack); end
      @(negedge clk); p0.req = 0; #1;
      tests_run++; if (p0.rvalid !== 1'b1 || p0.rdata !== 32'hDEADBEEF || p1.ack !== 1'b1) begin tests_failed++; $display("FAIL post_b2b got rvalid0=%b rdata0=%h ack1=%b want 1 deadbeef 1", p0.rvalid, p0.rdata, p1.ack); end
      @(negedge clk); idle_inputs(); #1;
      tests_run++; if (p1.rvalid !== 1'b1 || p1.rdata !== 32'h12345678) begin tests_failed++; $display("FAIL post_rd1 got rvalid1=%b rdata1=%h want 1 12345678", p1.rvalid, p1.rdata); end
   endtask

   initial begin
      test_reset();
      test_read();
      test_out_of_range();
      test_rr_writes();
      test_write_read();
      test_lock();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
